// File: rtl/counter_sequencer.sv
// Run/pause/step sequencer with a programmable prescaler that issues one-cycle
// tick enables for a wrapping up/down counter, all in a single clock domain.
module counter_sequencer #(
  parameter int DIV_WIDTH   = 25,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic                   dir,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic [DIV_WIDTH-1:0]   prescale,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tick,
  output logic                   wrap,
  output logic                   running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_pre_cnt;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_tick;
  logic                   r_wrap;
  logic                   r_running;

  logic                   w_match;
  logic                   w_adv;
  logic [COUNT_WIDTH-1:0] w_next_count;

  // >= rather than == so a prescale lowered below pre_cnt ticks at once.
  assign w_match      = (r_pre_cnt >= prescale);
  assign w_next_count = dir ? (r_count + COUNT_WIDTH'(1)) : (r_count - COUNT_WIDTH'(1));

  // Advance only when no higher-priority command claims the cycle; start in
  // RUN and step in RUN are no-ops, so RUN falls through to the prescaler.
  assign w_adv = !load && !stop &&
                 ((r_state == S_RUN) ? w_match : (!start && step));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pre_cnt <= '0;
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;

      if (load) begin
        r_count   <= load_val;
        r_pre_cnt <= '0;
      end else if (stop) begin
        case (r_state)
          S_RUN: begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
          S_PAUSE: begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pre_cnt <= '0;
          end
          default: ;
        endcase
      end else if (start && (r_state != S_RUN)) begin
        if (r_state == S_IDLE) begin
          r_pre_cnt <= '0;
        end
        r_state   <= S_RUN;
        r_running <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_pre_cnt <= w_match ? '0 : (r_pre_cnt + DIV_WIDTH'(1));
      end else if (r_state == S_IDLE) begin
        r_pre_cnt <= '0;
      end

      if (w_adv) begin
        r_count <= w_next_count;
        r_tick  <= 1'b1;
        r_wrap  <= dir ? (r_count == '1) : (r_count == '0);
      end
    end
  end

  assign count   = r_count;
  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign running = r_running;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run/pause/step controller and clock-enable generator for the board-level LED up/down counter. It replaces the ripple-clocked divider tap with a single-clock design. A programmable prescaler issues one-cycle `tick` enables. A small FSM sequences counting from start/stop/step/load commands. It sits between the switch/key inputs and the `LEDR` display, in the same 50 MHz clock domain.

## Interface
- `DIV_WIDTH`, default 25: width of the prescaler counter and of `prescale`.
- `COUNT_WIDTH`, default 4: width of `count`.
- `clk` in, 1: system clock, tied to `CLOCK_50` at top level.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: level command, enter or resume RUN.
- `stop` in, 1: level command; RUN→PAUSE, PAUSE→IDLE.
- `step` in, 1: single advance while IDLE or PAUSE.
- `dir` in, 1: 1 = count up, 0 = count down; sampled on each tick.
- `load` in, 1: synchronous load of `load_val`.
- `load_val` in, COUNT_WIDTH: value loaded into `count`.
- `prescale` in, DIV_WIDTH: tick period minus one, in clk cycles.
- `count` out, COUNT_WIDTH: current count, drives `LEDR`.
- `tick` out, 1: one-cycle pulse on each count advance.
- `wrap` out, 1: one-cycle pulse when a tick wraps `count`.
- `running` out, 1: high while the FSM is in RUN.

## Operation
- Reset (`reset_n`=0, asynchronous) sets:
  - `state`=IDLE, `count`=0, `pre_cnt`=0.
  - `tick`=0, `wrap`=0, `running`=0.
- FSM states:
  - IDLE: `count` held; `pre_cnt`=0.
  - RUN: the prescaler advances.
  - PAUSE: `count` and `pre_cnt` are frozen.
- Command priority, evaluated every cycle: `load` > `stop` > `start` > `step`. Only the highest-priority asserted command acts.
- `load`, any state: `count`←`load_val`, `pre_cnt`←0, no tick this cycle, state unchanged.
- `stop`:
  - In RUN: go to PAUSE.
  - In PAUSE: go to IDLE, with `count`←0 and `pre_cnt`←0.
  - In IDLE: no effect.
- `start`:
  - In IDLE: go to RUN with `pre_cnt`=0.
  - In PAUSE: go to RUN, resuming `pre_cnt` where it stopped.
  - In RUN: no effect.
- `step`:
  - In IDLE or PAUSE: exactly one tick on the next edge; state and `pre_cnt` unchanged.
  - Held high for N cycles: N ticks.
  - In RUN: ignored.
- Prescaler, in RUN only:
  - If `pre_cnt` ≥ `prescale`: `pre_cnt`←0 and tick.
  - Otherwise `pre_cnt`←`pre_cnt`+1.
  - The ≥ comparison means that lowering `prescale` mid-run below `pre_cnt` produces a tick on the next edge, never a 2^DIV_WIDTH stall.
  - `prescale`=0 produces a tick every cycle.
- On tick:
  - `count`←`count`±1, modulo 2^COUNT_WIDTH, with direction from the `dir` value sampled that cycle.
  - `wrap`=1 on the transitions max→0 (counting up) and 0→max (counting down).
- `running` equals (`state`==RUN) and is registered with the state.

## Timing
- All outputs are registered. `tick`, `wrap` and the new `count` appear together after the same rising edge.
- RUN tick period is exactly `prescale`+1 cycles. The first tick after `start` from IDLE occurs `prescale`+1 edges after the edge that samples `start`.
- Command latency is 1 edge. `running` rises on the edge that samples `start`.
- `step`: tick is high for exactly the cycle after the sampling edge.
- Ticks do not accumulate or queue. A `load` or `stop` on the same cycle as a prescaler match suppresses that tick.
- Reset asserted mid-run: outputs clear immediately, without waiting for a clock edge. After `reset_n` deasserts, the block stays in IDLE until a command arrives.
- With the defaults, `prescale`=24'd12_499_999 gives a 4 Hz count at 50 MHz.

## Test plan
- Reset, then `prescale`=3, `dir`=1, `start` pulsed for 1 cycle:
  - `tick` pulses every 4 cycles.
  - `count` goes 0,1,2,…; `running`=1.
- Continue the previous run to `count`=15 → next tick gives `count`=0 with `wrap`=1 for that one cycle only. Then set `dir`=0 at `count`=0 → next tick gives `count`=15 with `wrap`=1.
- Pause and resume: `stop` at `pre_cnt`=2 → PAUSE, and `count` stays frozen for 20 cycles. `start` → first tick arrives 2 cycles later, since `pre_cnt` resumes from 2 and ticks at 3.
- Step and stop from PAUSE: `step` held 3 cycles in PAUSE → exactly 3 ticks and `count`+3. A second `stop` → IDLE with `count`=0.
- Priority: `load`=1 with `load_val`=9, plus `stop` and `start`, on a prescaler-match cycle → `count`=9, no tick, state unchanged. Then `prescale` changed from 10 to 1 while `pre_cnt`=7 → tick on the next edge.
- Async reset: `reset_n` dropped mid-cycle during RUN with `count`=6 → `count`, `tick`, `wrap` and `running` read 0 before the next clock edge. After release, no ticks occur until `start`.
